// File: rtl/pipe_register.sv
`default_nettype none
// ============================================================================
// pipe_register : DEPTH-stage valid/ready register chain with per-stage bubble
//                 collapsing, synchronous flush and an occupancy count.
// Revision      : 1.0
// ============================================================================
module pipe_register #(
  parameter int N     = 8,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [N-1:0]     d_q [DEPTH];
  logic [N-1:0]     d_d [DEPTH];
  logic [DEPTH-1:0] adv;

  // A stage is blocked only when it and every stage ahead of it are full
  // while the output stalls; computing it as a suffix-AND keeps the chain flat.
  always_comb begin : p_adv
    logic full_run;
    full_run = 1'b1;
    adv      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full_run = full_run & v_q[i];
      adv[i]   = ~full_run | out_ready;
    end
  end

  always_comb begin : p_next
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    if (flush) begin
      v_d = '0;
    end else begin
      if (adv[0]) begin
        v_d[0] = in_valid;
        if (in_valid) begin
          d_d[0] = in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            d_d[i] = d_q[i-1];
          end
        end
      end
    end
  end

  always_comb begin : p_out
    in_ready  = adv[0] & ~flush;
    out_valid = v_q[DEPTH-1];
    out_data  = d_q[DEPTH-1];
    count     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(v_q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin : p_regs
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_register.sv
`default_nettype none
// ============================================================================
// tb_pipe_register : table-driven and scoreboard checks of pipe_register,
//                    including DEPTH=1 and DEPTH=8 random-stream instances.
// Revision         : 1.0
// ============================================================================
module tb_pipe_register;

  localparam int N     = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [CW-1:0] count;

  // sweep instances share one random stream
  logic        s_valid;
  logic        s_ready;
  logic        s_flush;
  logic [31:0] s_data;
  logic        ir1, ov1;
  logic [0:0]  od1;
  logic [0:0]  cnt1;
  logic        ir8, ov8;
  logic [31:0] od8;
  logic [3:0]  cnt8;

  int n_vec;
  int n_err;

  logic [N-1:0] sbq [$];
  logic [0:0]   q1  [$];
  logic [31:0]  q8  [$];

  typedef struct packed {
    logic          fl;
    logic          iv;
    logic [N-1:0]  id;
    logic          ordy;
    logic          ir;
    logic [CW-1:0] cnt;
    logic          ov;
    logic [N-1:0]  od;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  pipe_register #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  pipe_register #(.N(1), .DEPTH(1)) u_d1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (s_flush),
    .in_valid  (s_valid),
    .in_ready  (ir1),
    .in_data   (s_data[0:0]),
    .out_valid (ov1),
    .out_ready (s_ready),
    .out_data  (od1),
    .count     (cnt1)
  );

  pipe_register #(.N(32), .DEPTH(8)) u_d8 (
    .clk       (clk),
    .reset     (reset),
    .flush     (s_flush),
    .in_valid  (s_valid),
    .in_ready  (ir8),
    .in_data   (s_data),
    .out_valid (ov8),
    .out_ready (s_ready),
    .out_data  (od8),
    .count     (cnt8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic fl, input logic iv, input logic [N-1:0] id, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
  endtask

  // Scoreboard update for the transfers that happen at the coming edge.
  task automatic finish_cyc();
    logic [N-1:0] e;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_output", 32'(out_data), 32'hDEAD);
      end else begin
        e = sbq.pop_front();
        check("sb_out_data", 32'(out_data), 32'(e));
      end
    end
    if (in_valid && in_ready && !flush) sbq.push_back(in_data);
    if (flush) sbq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_step();
    logic [31:0] e;
    @(negedge clk);
    check("d1_count_vs_model", 32'(cnt1), 32'(q1.size()));
    check("d8_count_vs_model", 32'(cnt8), 32'(q8.size()));
    check("d8_count_le_depth", 32'(cnt8 <= 4'd8), 32'd1);
    if (ov1 && s_ready) begin
      e = (q1.size() != 0) ? 32'(q1.pop_front()) : 32'hDEAD;
      check("d1_out_data", 32'(od1), e);
    end
    if (ov8 && s_ready) begin
      e = (q8.size() != 0) ? q8.pop_front() : 32'hDEAD_BEEF;
      check("d8_out_data", od8, e);
    end
    if (s_valid && ir1) q1.push_back(s_data[0:0]);
    if (s_valid && ir8) q8.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    //              fl    iv    id     ordy  ir    cnt   ov    od
    tbl[0]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 2'd1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 2'd2, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 2'd3, 1'b1, 8'hA1};
    tbl[4]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 2'd3, 1'b1, 8'hA1};
    tbl[5]  = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 2'd3, 1'b1, 8'hA1};
    tbl[6]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 2'd3, 1'b1, 8'hA2};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 1'b1, 8'hA3};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b1, 8'hA4};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b1, 8'hA5};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 8'h00};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_valid = 1'b0; s_ready = 1'b0; s_flush = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_count",     32'(count),     32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // backpressure fill and drain
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
      check($sformatf("bp%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
      check($sformatf("bp%0d_count", i),     32'(count),     32'(tbl[i].cnt));
      check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) check($sformatf("bp%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      finish_cyc();
    end
    check("bp_all_drained", 32'(sbq.size()), 32'd0);

    // streaming: 0x01..0x0A, first output 3 cycles after first push
    for (int c = 0; c < 14; c++) begin
      apply(1'b0, (c < 10), 8'(c + 1), 1'b1);
      check($sformatf("st%0d_in_ready", c), 32'(in_ready), 32'd1);
      check($sformatf("st%0d_out_valid", c), 32'(out_valid), 32'(c >= 3 && c <= 12));
      if (c >= 3 && c <= 12) check($sformatf("st%0d_out_data", c), 32'(out_data), 32'(c - 2));
      finish_cyc();
    end

    // bubble collapse with output stalled
    apply(1'b0, 1'b1, 8'h11, 1'b0); finish_cyc();
    apply(1'b0, 1'b0, 8'h00, 1'b0); finish_cyc();
    apply(1'b0, 1'b0, 8'h00, 1'b0); finish_cyc();
    apply(1'b0, 1'b1, 8'h22, 1'b0);
    check("bub_in_ready_push2", 32'(in_ready), 32'd1);
    finish_cyc();
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    check("bub_count",     32'(count),     32'd2);
    check("bub_in_ready",  32'(in_ready),  32'd1);
    check("bub_out_valid", 32'(out_valid), 32'd1);
    check("bub_out_data",  32'(out_data),  32'h11);
    finish_cyc();
    apply(1'b0, 1'b0, 8'h00, 1'b1); finish_cyc();
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    check("bub_second_b2b_valid", 32'(out_valid), 32'd1);
    check("bub_second_b2b_data",  32'(out_data),  32'h22);
    finish_cyc();
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    check("bub_empty_count", 32'(count), 32'd0);
    finish_cyc();

    // flush with a full pipe and a pending input
    apply(1'b0, 1'b1, 8'hB1, 1'b0); finish_cyc();
    apply(1'b0, 1'b1, 8'hB2, 1'b0); finish_cyc();
    apply(1'b0, 1'b1, 8'hB3, 1'b0); finish_cyc();
    apply(1'b1, 1'b1, 8'h55, 1'b0);
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_count_before", 32'(count), 32'd3);
    finish_cyc();
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    check("fl_count_after", 32'(count), 32'd0);
    check("fl_out_valid_after", 32'(out_valid), 32'd0);
    finish_cyc();
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("fl_no_0x55_%0d", c), 32'(out_valid), 32'd0);
      finish_cyc();
    end

    // asynchronous reset mid-stream with count = 2
    apply(1'b0, 1'b1, 8'hC1, 1'b0); finish_cyc();
    apply(1'b0, 1'b1, 8'hC2, 1'b0); finish_cyc();
    in_valid = 1'b0;
    check("ar_count_before", 32'(count), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_data",  32'(out_data),  32'd0);
    check("ar_count",     32'(count),     32'd0);
    check("ar_in_ready",  32'(in_ready),  32'd1);
    sbq.delete();
    q1.delete();
    q8.delete();
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    apply(1'b0, 1'b1, 8'hD1, 1'b1);
    check("ar_lat_c0", 32'(out_valid), 32'd0);
    finish_cyc();
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    check("ar_lat_c1", 32'(out_valid), 32'd0);
    finish_cyc();
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    check("ar_lat_c2", 32'(out_valid), 32'd0);
    finish_cyc();
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    check("ar_lat_c3_valid", 32'(out_valid), 32'd1);
    check("ar_lat_c3_data",  32'(out_data),  32'hD1);
    finish_cyc();

    // parameter sweep: random valid/ready stream against FIFO models
    for (int c = 0; c < 400; c++) begin
      s_valid = ($urandom % 4) != 0;
      s_ready = ($urandom % 3) != 0;
      s_data  = $urandom;
      sweep_step();
    end
    s_valid = 1'b0;
    s_ready = 1'b1;
    for (int c = 0; c < 12; c++) sweep_step();
    check("d1_drained", 32'(q1.size()), 32'd0);
    check("d8_drained", 32'(q8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_register.md
# pipe_register

Parametrised N-bit, DEPTH-stage pipeline register chain with a valid/ready handshake on both sides, per-stage bubble collapsing, a synchronous flush and an occupancy count. It supersedes the single enable register wherever a data path must be retimed by several cycles while honouring downstream backpressure. Typical uses are ahead of and after the synchronizer blocks, and as the retiming stage of the handshake CDC path on the source-clock side. All logic is in one clock domain.

## Interface
- N, 8, data width in bits (≥1)
- DEPTH, 3, number of register stages (≥1)
- CW, $clog2(DEPTH+1), width of count; derived, not overridden
- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous clear of all stages
- in_valid  input  1  upstream has data on in_data
- in_ready  output  1  pipe accepts in_data this cycle
- in_data  input  N  upstream data
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  N  data of stage DEPTH-1
- count  output  CW  number of valid stages, 0..DEPTH

## Operation
- State per stage i (0 = input side, DEPTH-1 = output side): valid bit v[i] and data d[i][N-1:0].
- Advance terms (combinational):
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready
  - adv[i] = !v[i] | adv[i+1] for i < DEPTH-1
- in_ready = adv[0] & !flush.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1]; count = popcount(v).
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- At each clock edge with flush = 0, for every stage with adv[i] = 1:
  - v[i] <= source valid, where the source is in_valid for i = 0 and v[i-1] otherwise.
  - d[i] <= source data, but only when the source valid is 1.
- Stages with adv[i] = 0 hold both v and d.
- Bubble collapse: an empty stage always accepts from the stage behind it, even while the output is stalled. Up to DEPTH items are stored with no loss and no duplication.
- Data in stages with v = 0 is don't-care, but it must not change out_data while out_valid = 1 and out_ready = 0.
- flush = 1 at an edge:
  - All v[i] <= 0.
  - in_data is not captured.
  - d registers may hold their values.
  - An output transfer in the flush cycle (out_valid & out_ready) counts as delivered. No input transfer occurs in that cycle, because in_ready = 0.
- reset = 1: asynchronously forces all v = 0 and all d = 0. Takes effect mid-operation with no handshake; in-flight data is lost.

## Timing
- Reset values:
  - in_ready = 1 (while flush = 0)
  - out_valid = 0
  - out_data = 0
  - count = 0
- Latency: an item accepted at edge k appears with out_valid = 1 after edge k+DEPTH-1, i.e. DEPTH cycles from presentation, provided no stall occurs.
- Throughput: one item per cycle when out_ready stays 1.
- in_ready depends combinationally on out_ready through the adv chain. That path is DEPTH levels deep; this is accepted.
- Full condition: count = DEPTH and out_ready = 0 gives in_ready = 0.
- Simultaneous push and pop when full: out_ready = 1 gives in_ready = 1. Count stays DEPTH.
- count updates one cycle after each transfer:
  - +1 for an input transfer only
  - -1 for an output transfer only
  - unchanged for both or neither
  - forced to 0 by flush
- DEPTH = 1 degenerates to a single-stage register with in_ready = !v[0] | out_ready.

## Test plan
- Reset: assert reset mid-stream with DEPTH = 3 and count = 2 -> immediately out_valid = 0, out_data = 0, count = 0, in_ready = 1. After release, the first item pushed appears 3 cycles later.
- Streaming: out_ready = 1, push 0x01..0x0A on consecutive cycles -> out_data shows 0x01..0x0A on consecutive cycles starting 3 cycles after the first push, with no gaps.
- Backpressure fill: out_ready = 0, in_valid = 1 with 0xA1..0xA5 -> 0xA1..0xA3 accepted, then in_ready = 0 and count = 3, out_data = 0xA1 held steady. Raising out_ready drains 0xA1, 0xA2, 0xA3, 0xA4, 0xA5 in order.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22, with out_ready = 0 throughout -> count = 2, in_ready = 1, and 0x11 and 0x22 occupy stages 2 and 1.
- Flush: with count = 3, assert flush for 1 cycle with in_valid = 1 and in_data = 0x55 -> in_ready = 0 that cycle, then count = 0 and out_valid = 0. 0x55 never appears at the output.
- Parameter sweep: N = 1 / DEPTH = 1 and N = 32 / DEPTH = 8 -> a random valid/ready stream matches a scoreboard FIFO exactly, and count never exceeds DEPTH.
